// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Serializes configuration words onto the eFPGA configuration chain head.
//   Words arrive on a valid/ready handshake and are shifted MSB-first, one bit
//   per cycle with prog_clk_en high. After exactly CHAIN_LEN data shifts the
//   block reports done.
//
//   Optional build macro CCFF_LOOPBACK_CHECK_EN: prepends an 8-bit MARKER to the
//   stream and checks it as it falls out of ccff_tail. A mismatch raises the
//   sticky error flag.
//
// Ports
//   prog_clk     configuration clock; all state changes on its rising edge
//   prog_reset   synchronous active-high reset
//   start        one-cycle pulse; begins a load from IDLE or DONE
//   cfg_data     bitstream word; bit WORD_W-1 is shifted first
//   cfg_valid    cfg_data valid
//   cfg_ready    word accepted on an edge with cfg_valid && cfg_ready
//   ccff_head    serial bit into the chain
//   prog_clk_en  fabric clock-gate enable, aligned with ccff_head
//   ccff_tail    chain loopback (checked only with CCFF_LOOPBACK_CHECK_EN)
//   busy         load in progress
//   done         load complete; held until the next start or reset
//   error        loopback mismatch (constant 0 without the macro)
//
// state    | meaning
// IDLE     | waiting for start after reset
// MARKER   | shifting the 8 check bits (loopback build only)
// LOAD     | accepting words and shifting bitstream bits
// DONE     | all shifts issued; waiting for start
module ccff_bitstream_loader #(
  parameter int          WORD_W    = 32,
  parameter int          CHAIN_LEN = 1024,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  MARKER    = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

`ifdef CCFF_LOOPBACK_CHECK_EN
  localparam int MK_LEN = 8;
`else
  localparam int MK_LEN = 0;
`endif
  localparam int TOTAL     = CHAIN_LEN + MK_LEN;
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int REM_W     = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MARKER, S_LOAD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;      // shift number of the bit currently presented
  logic [CNT_W-1:0]    words_q, words_d;  // words accepted this load
  logic [WORD_W-1:0]   sh_q, sh_d;        // bits not yet presented, left-aligned
  logic [REM_W-1:0]    rem_q, rem_d;      // count of bits left in sh_q / marker
  logic                head_d, en_d, ready_d, busy_d, done_d, err_d;
  logic                accept;

`ifdef CCFF_LOOPBACK_CHECK_EN
  logic [7:0] mk_q, mk_d;
  logic [2:0] mk_idx;
  // Edge k = CHAIN_LEN+1+i expects MARKER bit 7-i at the tail; ~i == 7-i in 3 bits.
  assign mk_idx = 3'(cnt_q - CNT_W'(CHAIN_LEN + 1));
`else
  logic       unused_tail;
  logic [7:0] unused_marker;
  assign unused_tail   = ccff_tail;
  assign unused_marker = MARKER;
`endif

  assign accept = cfg_valid && cfg_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    head_d  = ccff_head;
    en_d    = 1'b0;
    ready_d = 1'b0;
    done_d  = done;
    err_d   = error;
`ifdef CCFF_LOOPBACK_CHECK_EN
    mk_d    = mk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          words_d = '0;
          sh_d    = '0;
`ifdef CCFF_LOOPBACK_CHECK_EN
          state_d = S_MARKER;
          head_d  = MARKER[7];
          en_d    = 1'b1;
          cnt_d   = CNT_W'(1);
          mk_d    = {MARKER[6:0], 1'b0};
          rem_d   = REM_W'(7);
`else
          state_d = S_LOAD;
          cnt_d   = '0;
          rem_d   = '0;
          ready_d = 1'b1;
`endif
        end
      end
`ifdef CCFF_LOOPBACK_CHECK_EN
      S_MARKER: begin
        if (rem_q != '0) begin
          head_d = mk_q[7];
          mk_d   = {mk_q[6:0], 1'b0};
          rem_d  = rem_q - REM_W'(1);
          en_d   = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_LOAD;
          ready_d = 1'b1;
        end
      end
`endif
      S_LOAD: begin
        if (prog_clk_en && cnt_q == CNT_W'(TOTAL)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (accept) begin
          head_d  = cfg_data[WORD_W-1];
          sh_d    = cfg_data << 1;
          // The final word may be only partly used; its low bits are dropped.
          rem_d   = (words_q == CNT_W'(NWORDS - 1)) ? REM_W'(LAST_BITS - 1)
                                                    : REM_W'(WORD_W - 1);
          words_d = words_q + CNT_W'(1);
          en_d    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (rem_q != '0) begin
          head_d = sh_q[WORD_W-1];
          sh_d   = sh_q << 1;
          rem_d  = rem_q - REM_W'(1);
          en_d   = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // Ready while the last buffered bit is presented, so words go back-to-back.
        ready_d = (state_d == S_LOAD) && (rem_d == '0) && (words_d < CNT_W'(NWORDS));
`ifdef CCFF_LOOPBACK_CHECK_EN
        if (prog_clk_en && cnt_q > CNT_W'(CHAIN_LEN) && ccff_tail != MARKER[~mk_idx])
          err_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_MARKER);
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      words_q     <= '0;
      sh_q        <= '0;
      rem_q       <= '0;
      ccff_head   <= 1'b0;
      prog_clk_en <= 1'b0;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef CCFF_LOOPBACK_CHECK_EN
      mk_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      ccff_head   <= head_d;
      prog_clk_en <= en_d;
      cfg_ready   <= ready_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= err_d;
`ifdef CCFF_LOOPBACK_CHECK_EN
      mk_q        <= mk_d;
`endif
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;
  localparam int         WW   = 16;
  localparam int         CL   = 40;
  localparam logic [7:0] MARK = 8'hA5;
  localparam int         NW   = (CL + WW - 1) / WW;
`ifdef CCFF_LOOPBACK_CHECK_EN
  localparam int MK = 8;
`else
  localparam int MK = 0;
`endif
  localparam int TOTAL = CL + MK;

  logic          prog_clk, prog_reset, start, cfg_valid, cfg_ready;
  logic [WW-1:0] cfg_data;
  logic          ccff_head, prog_clk_en, ccff_tail, busy, done, error;

  logic [CL-1:0] chain = '0;
  logic          inj_now;
  int            n_total = 0;
  int            n_bad   = 0;

  ccff_bitstream_loader #(.WORD_W(WW), .CHAIN_LEN(CL), .CNT_W(16), .MARKER(MARK)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .prog_clk_en(prog_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Fabric chain: captures ccff_head on enabled edges; optional single-bit tail fault.
  always @(posedge prog_clk) if (prog_clk_en) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1] ^ inj_now;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: valid always high; 1: random valid; 2: 5-cycle valid drop after word 1
  task automatic run_load(input int mode, input bit poke, input int reset_at, input bit inject);
    logic [WW-1:0] w [4];
    bit   cap[$];
    bit   expq[$];
    int   nsh = 0, widx = 0, zero_cyc = 0, hold_err = 0, ready_err = 0;
    int   stall_cnt = 0, bad_bits = 0, post_err = 0;
    bit   seen_last = 0, finished = 0, poked = 0, hs = 0, prev_hd = 0, vld = 0;
    for (int i = 0; i < 4; i++) w[i] = WW'($urandom);
    for (int i = 0; i < MK; i++) expq.push_back(MARK[7-i]);
    for (int i = 0; i < CL; i++) expq.push_back(w[i/WW][WW-1-(i%WW)]);

    @(negedge prog_clk);
    start = 1'b1;
    cfg_valid = 1'b0;
    @(posedge prog_clk);
    @(negedge prog_clk);
    check("start_state", {busy, done, error}, 3'b100);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (cyc > 0) @(negedge prog_clk);
      start = 1'b0;
      inj_now = 1'b0;
      if (seen_last) begin
        check("done_state", {done, busy, prog_clk_en, cfg_ready}, 4'b1000);
        finished = 1;
      end else begin
        if (prog_clk_en) begin
          cap.push_back(ccff_head);
          nsh++;
          if (mode == 0 && nsh > MK && (nsh - MK) % WW == 0 && (nsh - MK) < CL && cfg_ready !== 1'b1)
            ready_err++;
          if (inject && nsh == CL + 3) inj_now = 1'b1;
          if (nsh == TOTAL) seen_last = 1;
        end else begin
          if (nsh > MK) zero_cyc++;
          if (nsh > 0 && ccff_head !== prev_hd) hold_err++;
        end
        prev_hd = ccff_head;
        if (reset_at > 0 && nsh == reset_at) begin
          prog_reset = 1'b1;
          cfg_valid = 1'b1;
          @(posedge prog_clk);
          @(negedge prog_clk);
          check("reset_outs", {cfg_ready, ccff_head, prog_clk_en, busy, done, error}, 6'b0);
          prog_reset = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(posedge prog_clk);
            @(negedge prog_clk);
            if (prog_clk_en !== 1'b0 || cfg_ready !== 1'b0) post_err++;
          end
          check("post_reset_quiet", post_err, 0);
          cfg_valid = 1'b0;
          return;
        end
        if (poke && nsh == 10 && !poked) begin
          start = 1'b1;
          poked = 1;
        end
        case (mode)
          0: vld = 1'b1;
          1: vld = ($urandom % 3) != 0;
          default: begin
            if (widx == 1 && cfg_ready && stall_cnt < 5) begin
              vld = 1'b0;
              stall_cnt++;
            end else vld = 1'b1;
          end
        endcase
        cfg_valid = vld;
        cfg_data  = (widx < 4) ? w[widx] : '0;
        hs = vld && cfg_ready;
      end
      @(posedge prog_clk);
      if (hs) widx++;
      hs = 0;
    end

    check("finished", 32'(finished), 1);
    check("shift_count", nsh, TOTAL);
    check("handshakes", widx, NW);
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] != expq[i]) bad_bits++;
    check("bitstream_bits", bad_bits, 0);
    check("head_hold", hold_err, 0);
    if (mode == 0) begin
      check("b2b_ready", ready_err, 0);
      check("b2b_gap", zero_cyc, 0);
    end
    if (mode == 2) check("stall_cycles", zero_cyc, 5);
`ifdef CCFF_LOOPBACK_CHECK_EN
    check("loopback_error", 32'(error), 32'(inject));
    bad_bits = 0;
    for (int i = 0; i < CL; i++)
      if (chain[CL-1-i] !== expq[MK+i]) bad_bits++;
    check("chain_content", bad_bits, 0);
`else
    check("error_tied", 32'(error), 0);
`endif
  endtask

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    inj_now    = 1'b0;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check("reset_outs_init", {cfg_ready, ccff_head, prog_clk_en, busy, done, error}, 6'b0);
    prog_reset = 1'b0;

    run_load(0, 0, 0, 0);
    run_load(2, 0, 0, 0);
    run_load(0, 1, 0, 0);
    run_load(1, 0, 20, 0);
    run_load(0, 0, 0, 0);
    for (int r = 0; r < 4; r++) run_load(1, 1'($urandom % 2), 0, 0);
`ifdef CCFF_LOOPBACK_CHECK_EN
    run_load(0, 0, 0, 1);
    run_load(1, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
